csr_mmode_irq: RTL and testbench
================================

Name: csr_mmode_irq

Overview:
Parametrised machine-mode CSR file with a multi-source interrupt controller. It is the successor of the single-IRQ CSR unit and sits beside the execute stage. It provides:
- CSR read/modify/write with privilege and read-only checking
- 64-bit wrapping counters with inhibit control
- N synchronised local interrupt lines plus external, timer and software interrupts
- Fixed priority arbitration and direct or vectored trap entry
- mret return, with a single registered PC-redirect pulse

Parameters:
NUM_LOCAL, 4, local interrupt lines, mapped to mip/mie bits 16..16+NUM_LOCAL-1 (1..16)
SYNC_STAGES, 2, flip-flop synchroniser depth on every interrupt input (>=1)
VECTORED_EN, 1, 1 allows mtvec MODE=1; 0 forces MODE to 0 (WARL)
RESET_MTVEC, 32'h0000_0100, mtvec value after reset
HART_ID, 0, value returned by mhartid

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
cur_priv  in  2  current privilege (00 U, 11 M)
csr_valid  in  1  CSR instruction in execute this cycle
csr_addr  in  12  CSR address
csr_op  in  2  01 RW, 10 RS, 11 RC
csr_wdata  in  32  rs1 value or zero-extended zimm, already selected
csr_wr_suppress  in  1  rs1/zimm is x0/0 on RS/RC: read only, no write
csr_rdata  out  32  old CSR value, combinational
csr_illegal  out  1  combinational illegal-access flag
exc_valid  in  1  synchronous exception
exc_pc  in  32  faulting PC
exc_cause  in  5  exception code
exc_tval  in  32  trap value
mret  in  1  mret in execute
retire  in  1  instruction retired this cycle
int_allow  in  1  pipeline at an interruptible boundary
int_pc  in  32  PC of next unexecuted instruction
irq_ext, irq_timer, irq_sw  in  1 each  asynchronous level interrupts
irq_local  in  NUM_LOCAL  asynchronous level interrupts
redirect_valid  out  1  registered one-cycle pulse
redirect_pc  out  32  target PC, valid with redirect_valid
next_priv  out  2  registered privilege
irq_taken  out  1  pulse, coincident with redirect_valid on interrupt entry

Behaviour:
Reset values:
- mstatus=0 with MPP=11
- mie, mepc, mcause, mtval, mscratch = 0
- mtvec=RESET_MTVEC
- mcycle, minstret, mcountinhibit = 0
- synchronisers = 0
- outputs: redirect_valid=0, redirect_pc=0, next_priv=11, irq_taken=0
- Reset asserted mid-trap cancels any pending redirect.

Implemented CSRs (any other address is illegal):
- mstatus 0x300
- misa 0x301 (RV32IM, read-only value)
- mie 0x304
- mtvec 0x305
- mcountinhibit 0x320
- mscratch 0x340
- mepc 0x341
- mcause 0x342
- mtval 0x343
- mip 0x344
- mcycle/h 0xB00/0xB80
- minstret/h 0xB02/0xB82
- mvendorid/marchid/mimpid/mhartid 0xF11-0xF14

csr_illegal asserts when csr_valid and any of the following holds:
- the address is unimplemented
- cur_priv < addr[9:8]
- addr[11:10]==11 and the write is not suppressed

While csr_illegal is high, csr_rdata=0 and no state changes.

Write rules:
- new value = RW: wdata; RS: old|wdata; RC: old&~wdata.
- Writes take effect at the clock edge; csr_rdata always returns the pre-write value.

WARL fields:
- mstatus writable bits are MIE(3), MPIE(7) and MPP(12:11). An MPP write of 01 or 10 keeps the old MPP.
- mepc[1:0] is always 0.
- mtvec[1:0] accepts 00/01 when VECTORED_EN=1; otherwise it is always 00.
- mie writable bits are 3, 7, 11 and 16..16+NUM_LOCAL-1.
- mip is read-only: it reflects the synchronised levels at bits 3, 7, 11 and 16+i.

Counters:
- Counters are 64-bit and wrap from FFFF_FFFF_FFFF_FFFF to 0.
- mcycle increments every cycle unless mcountinhibit[0] is set.
- minstret increments on retire unless mcountinhibit[2] is set.
- A CSR write to either half wins over that cycle's increment. The other half still carries correctly.

Interrupt handling:
- Pending set P = mip & mie.
- Eligible when P!=0 and (mstatus.MIE or cur_priv!=11) and int_allow.
- Priority order: MEI(11) > MSI(3) > MTI(7) > local, with the higher local index winning.
- mcause on interrupt = {1, code}, where the local code is 16+i.

Same-cycle priority is exc_valid > mret > interrupt > CSR write. A CSR write that loses to a higher-priority event is dropped.

Trap entry (exception or interrupt), at the next edge:
- mepc <= exc_pc, or int_pc for an interrupt
- mcause set
- mtval <= exc_tval, or 0 for an interrupt
- MPIE <= MIE; MIE <= 0; MPP <= cur_priv
- next_priv <= 11
- redirect_valid pulses high for exactly one cycle
- redirect_pc = base, or for a vectored interrupt base + 4*code; exceptions always use base

mret:
- next_priv <= MPP
- MIE <= MPIE; MPIE <= 1; MPP <= 00
- redirect_pc = mepc
- mret with cur_priv!=11 is ignored.

Test Plan:
- Reset released, no stimulus, 10 cycles -> mtvec=0x100, next_priv=11, redirect_valid never set, mcycle reads 10 +/-1.
- U-mode read of 0x300 -> csr_illegal=1, csr_rdata=0, mstatus unchanged.
- mtvec=0x1001, mie=1<<17, MIE=1, irq_local[1] held high, int_pc=0x40 -> after SYNC_STAGES+1 cycles, one pulse with redirect_pc=0x1000+4*17=0x1044, mcause=0x8000_0011, mepc=0x40, MIE=0, MPIE=1, irq_taken=1.
- Same cycle: exc_valid (cause 2, pc 0x80) with an eligible MEI -> exception wins: mcause=2, redirect_pc=mtvec base, irq_taken=0.
- Write mcycle=FFFF_FFFF with mcycleh=0 -> two cycles later mcycleh=1 and mcycle=0.
- mret with mepc=0x200 and MPP=00 -> next_priv=00, redirect_pc=0x200, MIE restored from MPIE, MPIE=1.

Source files
------------

// File: rtl/csr_mmode_irq.sv
// csr_mmode_irq: machine-mode CSR file with synchronised multi-source interrupts,
// fixed-priority arbitration, direct/vectored trap entry and mret.
module csr_mmode_irq #(
    parameter int          NUM_LOCAL   = 4,
    parameter int          SYNC_STAGES = 2,
    parameter bit          VECTORED_EN = 1'b1,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter int          HART_ID     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           cur_priv_i,
    input  logic                 csr_valid_i,
    input  logic [11:0]          csr_addr_i,
    input  logic [1:0]           csr_op_i,
    input  logic [31:0]          csr_wdata_i,
    input  logic                 csr_wr_suppress_i,
    output logic [31:0]          csr_rdata_o,
    output logic                 csr_illegal_o,
    input  logic                 exc_valid_i,
    input  logic [31:0]          exc_pc_i,
    input  logic [4:0]           exc_cause_i,
    input  logic [31:0]          exc_tval_i,
    input  logic                 mret_i,
    input  logic                 retire_i,
    input  logic                 int_allow_i,
    input  logic [31:0]          int_pc_i,
    input  logic                 irq_ext_i,
    input  logic                 irq_timer_i,
    input  logic                 irq_sw_i,
    input  logic [NUM_LOCAL-1:0] irq_local_i,
    output logic                 redirect_valid_o,
    output logic [31:0]          redirect_pc_o,
    output logic [1:0]           next_priv_o,
    output logic                 irq_taken_o
);
    localparam int          W        = 3 + NUM_LOCAL;
    localparam logic [31:0] MIE_MASK = 32'h0000_0888 | (32'((64'd1 << NUM_LOCAL) - 64'd1) << 16);
    localparam logic [31:0] RST_TVEC = {RESET_MTVEC[31:2], 1'b0, VECTORED_EN & RESET_MTVEC[0]};

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [1:0]  mst_mpp_q, mst_mpp_d, next_priv_q, next_priv_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [2:0]  mcountinhibit_q, mcountinhibit_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic        redirect_valid_q, redirect_valid_d, irq_taken_q, irq_taken_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] mstatus, mip, rval, wval, pend, tvec_base;
    logic        impl, illegal, mret_ok, eligible, int_take, csr_we;
    logic [4:0]  int_code;

    assign mstatus   = {19'd0, mst_mpp_q, 3'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};
    assign tvec_base = {mtvec_q[31:2], 2'b00};

    always_comb begin
        mip = '0;
        mip[3] = sync_q[SYNC_STAGES-1][0];
        mip[7] = sync_q[SYNC_STAGES-1][1];
        mip[11] = sync_q[SYNC_STAGES-1][2];
        mip[16 +: NUM_LOCAL] = sync_q[SYNC_STAGES-1][W-1:3];
    end

    always_comb begin
        rval = '0;
        impl = 1'b1;
        case (csr_addr_i)
            12'h300: rval = mstatus;
            12'h301: rval = 32'h4000_1100;
            12'h304: rval = mie_q;
            12'h305: rval = mtvec_q;
            12'h320: rval = {29'd0, mcountinhibit_q};
            12'h340: rval = mscratch_q;
            12'h341: rval = mepc_q;
            12'h342: rval = mcause_q;
            12'h343: rval = mtval_q;
            12'h344: rval = mip;
            12'hB00: rval = mcycle_q[31:0];
            12'hB80: rval = mcycle_q[63:32];
            12'hB02: rval = minstret_q[31:0];
            12'hB82: rval = minstret_q[63:32];
            12'hF11, 12'hF12, 12'hF13: rval = '0;
            12'hF14: rval = 32'(HART_ID);
            default: impl = 1'b0;
        endcase
    end

    assign illegal = csr_valid_i && (!impl || cur_priv_i < csr_addr_i[9:8] ||
                     (csr_addr_i[11:10] == 2'b11 && !csr_wr_suppress_i));
    assign csr_illegal_o = illegal;
    assign csr_rdata_o   = illegal ? '0 : rval;
    assign wval = csr_op_i == 2'b01 ? csr_wdata_i :
                  csr_op_i == 2'b10 ? (rval | csr_wdata_i) : (rval & ~csr_wdata_i);

    assign mret_ok  = mret_i && cur_priv_i == 2'b11;
    assign pend     = mip & mie_q;
    assign eligible = |pend && (mst_mie_q || cur_priv_i != 2'b11) && int_allow_i;
    assign int_take = eligible && !exc_valid_i && !mret_ok;
    assign csr_we   = csr_valid_i && !illegal && !csr_wr_suppress_i && csr_op_i != 2'b00 &&
                      !exc_valid_i && !mret_ok && !int_take;

    // Later assignments win: MEI > MSI > MTI > highest local index.
    always_comb begin
        int_code = '0;
        for (int i = 0; i < NUM_LOCAL; i++) if (pend[16+i]) int_code = 5'(16 + i);
        if (pend[7]) int_code = 5'd7;
        if (pend[3]) int_code = 5'd3;
        if (pend[11]) int_code = 5'd11;
    end

    always_comb begin
        mst_mie_d        = mst_mie_q;
        mst_mpie_d       = mst_mpie_q;
        mst_mpp_d        = mst_mpp_q;
        mie_d            = mie_q;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        mcountinhibit_d  = mcountinhibit_q;
        mcycle_d         = mcycle_q + 64'(!mcountinhibit_q[0]);
        minstret_d       = minstret_q + 64'(retire_i && !mcountinhibit_q[2]);
        next_priv_d      = next_priv_q;
        redirect_pc_d    = redirect_pc_q;
        redirect_valid_d = 1'b0;
        irq_taken_d      = 1'b0;
        if (csr_we) begin
            case (csr_addr_i)
                12'h300: begin
                    mst_mie_d  = wval[3];
                    mst_mpie_d = wval[7];
                    mst_mpp_d  = (wval[12:11] == 2'b01 || wval[12:11] == 2'b10) ? mst_mpp_q : wval[12:11];
                end
                12'h304: mie_d = wval & MIE_MASK;
                12'h305: mtvec_d = {wval[31:2], 1'b0,
                                    (VECTORED_EN && wval[1:0] == 2'b01) ? 1'b1 :
                                    (wval[1:0] == 2'b00) ? 1'b0 : mtvec_q[0]};
                12'h320: mcountinhibit_d = wval[2:0] & 3'b101;
                12'h340: mscratch_d = wval;
                12'h341: mepc_d = wval & ~32'd3;
                12'h342: mcause_d = wval;
                12'h343: mtval_d = wval;
                12'hB00: mcycle_d[31:0] = wval;
                12'hB80: mcycle_d[63:32] = wval;
                12'hB02: minstret_d[31:0] = wval;
                12'hB82: minstret_d[63:32] = wval;
                default: ;
            endcase
        end
        if (exc_valid_i || int_take) begin
            mepc_d           = (exc_valid_i ? exc_pc_i : int_pc_i) & ~32'd3;
            mcause_d         = exc_valid_i ? {27'd0, exc_cause_i} : {1'b1, 26'd0, int_code};
            mtval_d          = exc_valid_i ? exc_tval_i : '0;
            mst_mpie_d       = mst_mie_q;
            mst_mie_d        = 1'b0;
            mst_mpp_d        = cur_priv_i;
            next_priv_d      = 2'b11;
            redirect_valid_d = 1'b1;
            irq_taken_d      = int_take;
            redirect_pc_d    = tvec_base + ((int_take && mtvec_q[0]) ? {25'd0, int_code, 2'b00} : 32'd0);
        end else if (mret_ok) begin
            next_priv_d      = mst_mpp_q;
            mst_mie_d        = mst_mpie_q;
            mst_mpie_d       = 1'b1;
            mst_mpp_d        = 2'b00;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mepc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q           <= '0;
            mst_mie_q        <= 1'b0;
            mst_mpie_q       <= 1'b0;
            mst_mpp_q        <= 2'b11;
            mie_q            <= '0;
            mtvec_q          <= RST_TVEC;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            mcountinhibit_q  <= '0;
            mcycle_q         <= '0;
            minstret_q       <= '0;
            next_priv_q      <= 2'b11;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            irq_taken_q      <= 1'b0;
        end else begin
            sync_q[0] <= {irq_local_i, irq_ext_i, irq_timer_i, irq_sw_i};
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            mst_mie_q        <= mst_mie_d;
            mst_mpie_q       <= mst_mpie_d;
            mst_mpp_q        <= mst_mpp_d;
            mie_q            <= mie_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            mcountinhibit_q  <= mcountinhibit_d;
            mcycle_q         <= mcycle_d;
            minstret_q       <= minstret_d;
            next_priv_q      <= next_priv_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            irq_taken_q      <= irq_taken_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign next_priv_o      = next_priv_q;
    assign irq_taken_o      = irq_taken_q;
endmodule

// File: tb/tb_csr_mmode_irq.sv
// tb_csr_mmode_irq: scenario tasks for csr_mmode_irq; redirect pulses are
// checked against a queue of expected (pc, irq_taken) pairs.
module tb_csr_mmode_irq;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] cur_priv = 2'b11, csr_op = 2'b00;
    logic csr_valid = 0, csr_wr_suppress = 0, exc_valid = 0, mret = 0, retire = 0, int_allow = 0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0, exc_pc = '0, exc_tval = '0, int_pc = '0;
    logic [4:0] exc_cause = '0;
    logic irq_ext = 0, irq_timer = 0, irq_sw = 0;
    logic [3:0] irq_local = '0;
    logic [31:0] csr_rdata, redirect_pc;
    logic csr_illegal, redirect_valid, irq_taken;
    logic [1:0] next_priv;

    typedef struct {logic [31:0] pc; logic irq;} exp_t;
    exp_t sbq[$];
    exp_t e_m;
    int checks = 0, failures = 0;

    csr_mmode_irq dut (
        .clk(clk), .rst_n(rst_n), .cur_priv_i(cur_priv), .csr_valid_i(csr_valid),
        .csr_addr_i(csr_addr), .csr_op_i(csr_op), .csr_wdata_i(csr_wdata),
        .csr_wr_suppress_i(csr_wr_suppress), .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
        .exc_valid_i(exc_valid), .exc_pc_i(exc_pc), .exc_cause_i(exc_cause), .exc_tval_i(exc_tval),
        .mret_i(mret), .retire_i(retire), .int_allow_i(int_allow), .int_pc_i(int_pc),
        .irq_ext_i(irq_ext), .irq_timer_i(irq_timer), .irq_sw_i(irq_sw), .irq_local_i(irq_local),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc), .next_priv_o(next_priv),
        .irq_taken_o(irq_taken)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && redirect_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL redirect_unexpected got pc=%h irq=%b", redirect_pc, irq_taken);
            end else begin
                e_m = sbq.pop_front();
                if (redirect_pc !== e_m.pc || irq_taken !== e_m.irq) begin
                    failures++;
                    $display("FAIL redirect got pc=%h irq=%b exp pc=%h irq=%b", redirect_pc, irq_taken, e_m.pc, e_m.irq);
                end
            end
        end else if (rst_n && irq_taken) begin
            failures++;
            $display("FAIL irq_taken_alone got=1 exp=0");
        end
    end

    task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_valid = 1; csr_addr = a; csr_op = op; csr_wdata = d; csr_wr_suppress = 0;
        @(posedge clk); #1;
        csr_valid = 0;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d, output logic ill);
        csr_valid = 1; csr_addr = a; csr_op = 2'b10; csr_wdata = 0; csr_wr_suppress = 1;
        #1 d = csr_rdata; ill = csr_illegal;
        csr_valid = 0; csr_wr_suppress = 0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        #1 checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d exp=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        logic [31:0] v; logic il;
        repeat (3) @(posedge clk); #1;
        checks++; if ({redirect_valid, irq_taken, next_priv} !== 4'b0011 || redirect_pc !== 0) begin
            failures++; $display("FAIL reset_outputs got rv=%b it=%b np=%b pc=%h exp 0 0 11 0", redirect_valid, irq_taken, next_priv, redirect_pc); end
        rst_n = 1;
        repeat (10) @(posedge clk); #1;
        csr_rd(12'hB00, v, il);
        checks++; if (v < 9 || v > 11) begin failures++; $display("FAIL reset_mcycle got=%0d exp=10", v); end
        csr_rd(12'h305, v, il);
        checks++; if (v !== 32'h100) begin failures++; $display("FAIL reset_mtvec got=%h exp=00000100", v); end
        csr_rd(12'h300, v, il);
        checks++; if (v !== 32'h1800) begin failures++; $display("FAIL reset_mstatus got=%h exp=00001800", v); end
        csr_rd(12'h301, v, il);
        checks++; if (v !== 32'h4000_1100) begin failures++; $display("FAIL misa got=%h exp=40001100", v); end
    endtask

    task automatic test_illegal();
        logic [31:0] v; logic il;
        cur_priv = 2'b00;
        csr_rd(12'h300, v, il);
        checks++; if (il !== 1'b1 || v !== 0) begin failures++; $display("FAIL umode_read got ill=%b d=%h exp 1 0", il, v); end
        csr_wr(12'h340, 2'b01, 32'h1234_5678);
        cur_priv = 2'b11;
        csr_rd(12'h340, v, il);
        checks++; if (v !== 0) begin failures++; $display("FAIL umode_write_blocked got=%h exp=0", v); end
        csr_rd(12'h300, v, il);
        checks++; if (v !== 32'h1800) begin failures++; $display("FAIL mstatus_unchanged got=%h exp=00001800", v); end
        csr_rd(12'h7C0, v, il);
        checks++; if (il !== 1'b1) begin failures++; $display("FAIL unimpl_addr got ill=%b exp=1", il); end
        csr_valid = 1; csr_addr = 12'hF14; csr_op = 2'b01; csr_wdata = 0; csr_wr_suppress = 0; #1;
        checks++; if (csr_illegal !== 1'b1) begin failures++; $display("FAIL ro_write got ill=%b exp=1", csr_illegal); end
        csr_valid = 0;
        csr_rd(12'hF14, v, il);
        checks++; if (il !== 1'b0 || v !== 0) begin failures++; $display("FAIL mhartid got ill=%b d=%h exp 0 0", il, v); end
    endtask

    task automatic test_csr_rw();
        logic [31:0] v; logic il;
        csr_wr(12'h340, 2'b01, 32'hA5A5_0F0F);
        csr_valid = 1; csr_addr = 12'h340; csr_op = 2'b10; csr_wdata = 32'h0000_F0F0; #1;
        checks++; if (csr_rdata !== 32'hA5A5_0F0F) begin failures++; $display("FAIL rs_old_value got=%h exp=a5a50f0f", csr_rdata); end
        @(posedge clk); #1 csr_valid = 0;
        csr_rd(12'h340, v, il);
        checks++; if (v !== 32'hA5A5_FFFF) begin failures++; $display("FAIL rs_result got=%h exp=a5a5ffff", v); end
        csr_wr(12'h340, 2'b11, 32'hA5A5_0000);
        csr_rd(12'h340, v, il);
        checks++; if (v !== 32'h0000_FFFF) begin failures++; $display("FAIL rc_result got=%h exp=0000ffff", v); end
        csr_wr(12'h341, 2'b01, 32'h0000_0203);
        csr_rd(12'h341, v, il);
        checks++; if (v !== 32'h200) begin failures++; $display("FAIL mepc_align got=%h exp=00000200", v); end
        csr_wr(12'h305, 2'b01, 32'h0000_1003);
        csr_rd(12'h305, v, il);
        checks++; if (v !== 32'h1000) begin failures++; $display("FAIL mtvec_warl got=%h exp=00001000", v); end
        csr_wr(12'h304, 2'b01, 32'hFFFF_FFFF);
        csr_rd(12'h304, v, il);
        checks++; if (v !== 32'h000F_0888) begin failures++; $display("FAIL mie_mask got=%h exp=000f0888", v); end
        csr_wr(12'h304, 2'b01, 0);
        csr_wr(12'h300, 2'b01, 32'h0000_1088);
        csr_rd(12'h300, v, il);
        checks++; if (v !== 32'h1888) begin failures++; $display("FAIL mpp_warl got=%h exp=00001888", v); end
        csr_wr(12'h300, 2'b01, 32'h0000_1800);
    endtask

    task automatic test_vectored_irq();
        logic [31:0] v; logic il; int n;
        csr_wr(12'h305, 2'b01, 32'h1001);
        csr_wr(12'h304, 2'b01, 32'h0002_0000);
        csr_wr(12'h300, 2'b01, 32'h1808);
        int_allow = 1; int_pc = 32'h40;
        sbq.push_back('{32'h1044, 1'b1});
        irq_local = 4'b0010; n = 0;
        while (n < 10) begin @(posedge clk); #1 n++; if (redirect_valid) break; end
        irq_local = 0; int_allow = 0;
        checks++; if (n !== 3) begin failures++; $display("FAIL irq_latency got=%0d exp=3", n); end
        wait_drain();
        csr_rd(12'h342, v, il);
        checks++; if (v !== 32'h8000_0011) begin failures++; $display("FAIL irq_mcause got=%h exp=80000011", v); end
        csr_rd(12'h341, v, il);
        checks++; if (v !== 32'h40) begin failures++; $display("FAIL irq_mepc got=%h exp=00000040", v); end
        csr_rd(12'h300, v, il);
        checks++; if (v !== 32'h1880) begin failures++; $display("FAIL irq_mstatus got=%h exp=00001880", v); end
        csr_wr(12'h304, 2'b01, 0);
    endtask

    task automatic test_exc_priority();
        logic [31:0] v; logic il;
        csr_wr(12'h304, 2'b01, 32'h800);
        csr_wr(12'h300, 2'b01, 32'h1808);
        irq_ext = 1;
        repeat (3) @(posedge clk); #1;
        sbq.push_back('{32'h1000, 1'b0});
        exc_valid = 1; exc_pc = 32'h80; exc_cause = 5'd2; exc_tval = 32'h1234; int_allow = 1;
        csr_wr(12'h340, 2'b01, 32'hDEAD);
        exc_valid = 0; int_allow = 0; irq_ext = 0;
        wait_drain();
        csr_rd(12'h342, v, il);
        checks++; if (v !== 32'd2) begin failures++; $display("FAIL exc_mcause got=%h exp=00000002", v); end
        csr_rd(12'h343, v, il);
        checks++; if (v !== 32'h1234) begin failures++; $display("FAIL exc_mtval got=%h exp=00001234", v); end
        csr_rd(12'h340, v, il);
        checks++; if (v !== 32'h0000_FFFF) begin failures++; $display("FAIL dropped_write got=%h exp=0000ffff", v); end
        checks++; if (next_priv !== 2'b11) begin failures++; $display("FAIL exc_next_priv got=%b exp=11", next_priv); end
        csr_wr(12'h304, 2'b01, 0);
    endtask

    task automatic test_priority();
        logic [31:0] v; logic il;
        logic [4:0] codes [3] = '{5'd3, 5'd7, 5'd19};
        csr_wr(12'h305, 2'b01, 32'h2001);
        csr_wr(12'h304, 2'b01, 32'h0008_0888);
        csr_wr(12'h300, 2'b01, 32'h1800);
        irq_sw = 1; irq_timer = 1; irq_local = 4'b1000;
        for (int r = 0; r < 3; r++) begin
            repeat (3) @(posedge clk); #1;
            cur_priv = 2'b00;
            sbq.push_back('{32'h2000 + 32'(codes[r]) * 4, 1'b1});
            int_allow = 1;
            @(posedge clk); #1;
            int_allow = 0; cur_priv = 2'b11;
            wait_drain();
            csr_rd(12'h342, v, il);
            checks++; if (v !== {27'h400_0000, codes[r]}) begin failures++; $display("FAIL prio_mcause got=%h exp code %0d", v, codes[r]); end
            if (r == 0) irq_sw = 0; else irq_timer = 0;
        end
        csr_rd(12'h300, v, il);
        checks++; if (v !== 0) begin failures++; $display("FAIL umode_trap_mstatus got=%h exp=0", v); end
        irq_local = 0;
        csr_wr(12'h304, 2'b01, 0);
    endtask

    task automatic test_counters();
        logic [31:0] v, a, b; logic il;
        csr_wr(12'hB80, 2'b01, 0);
        csr_wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        csr_rd(12'hB80, v, il);
        checks++; if (v !== 1) begin failures++; $display("FAIL carry_hi got=%h exp=1", v); end
        csr_rd(12'hB00, v, il);
        checks++; if (v !== 0) begin failures++; $display("FAIL carry_lo got=%h exp=0", v); end
        csr_wr(12'h320, 2'b01, 32'hFFFF_FFFF);
        csr_rd(12'h320, v, il);
        checks++; if (v !== 5) begin failures++; $display("FAIL inhibit_mask got=%h exp=5", v); end
        csr_rd(12'hB00, a, il);
        csr_rd(12'hB02, b, il);
        retire = 1;
        repeat (3) @(posedge clk); #1;
        retire = 0;
        csr_rd(12'hB00, v, il);
        checks++; if (v !== a) begin failures++; $display("FAIL inhibit_cycle got=%h exp=%h", v, a); end
        csr_rd(12'hB02, v, il);
        checks++; if (v !== b) begin failures++; $display("FAIL inhibit_instret got=%h exp=%h", v, b); end
        csr_wr(12'h320, 2'b01, 0);
        retire = 1;
        csr_wr(12'hB02, 2'b01, 100);
        retire = 0;
        csr_rd(12'hB02, v, il);
        checks++; if (v !== 100) begin failures++; $display("FAIL write_wins got=%0d exp=100", v); end
        retire = 1;
        repeat (5) @(posedge clk); #1;
        retire = 0;
        csr_rd(12'hB02, v, il);
        checks++; if (v !== 105) begin failures++; $display("FAIL instret_count got=%0d exp=105", v); end
    endtask

    task automatic test_mret();
        logic [31:0] v; logic il;
        csr_wr(12'h341, 2'b01, 32'h200);
        csr_wr(12'h300, 2'b01, 32'h0080);
        sbq.push_back('{32'h200, 1'b0});
        mret = 1;
        @(posedge clk); #1;
        mret = 0;
        checks++; if (next_priv !== 2'b00) begin failures++; $display("FAIL mret_priv got=%b exp=00", next_priv); end
        wait_drain();
        csr_rd(12'h300, v, il);
        checks++; if (v !== 32'h88) begin failures++; $display("FAIL mret_mstatus got=%h exp=00000088", v); end
        cur_priv = 2'b00; mret = 1;
        @(posedge clk); #1;
        mret = 0; cur_priv = 2'b11;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v; logic il;
        sbq.push_back('{32'h2000, 1'b0});
        sbq.push_back('{32'h2000, 1'b0});
        exc_valid = 1; exc_pc = 32'h300; exc_cause = 5'd5;
        @(posedge clk); #1;
        exc_pc = 32'h304; exc_cause = 5'd7;
        @(posedge clk); #1;
        exc_valid = 0;
        wait_drain();
        csr_rd(12'h341, v, il);
        checks++; if (v !== 32'h304) begin failures++; $display("FAIL b2b_mepc got=%h exp=00000304", v); end
        csr_rd(12'h342, v, il);
        checks++; if (v !== 7) begin failures++; $display("FAIL b2b_mcause got=%h exp=7", v); end
    endtask

    task automatic test_reset_midtrap();
        logic [31:0] v; logic il;
        exc_valid = 1; exc_pc = 32'h500; exc_cause = 5'd3;
        #2 rst_n = 0;
        @(posedge clk); #1;
        exc_valid = 0;
        checks++; if (redirect_valid !== 0 || irq_taken !== 0 || next_priv !== 2'b11) begin
            failures++; $display("FAIL midtrap_reset got rv=%b it=%b np=%b exp 0 0 11", redirect_valid, irq_taken, next_priv); end
        rst_n = 1;
        @(posedge clk); #1;
        csr_rd(12'h341, v, il);
        checks++; if (v !== 0) begin failures++; $display("FAIL midtrap_mepc got=%h exp=0", v); end
        csr_rd(12'h305, v, il);
        checks++; if (v !== 32'h100) begin failures++; $display("FAIL midtrap_mtvec got=%h exp=00000100", v); end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_csr_rw();
        test_vectored_irq();
        test_exc_priority();
        test_priority();
        test_counters();
        test_mret();
        test_back_to_back();
        test_reset_midtrap();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
